debug_step_ctrl: RTL

Debug execution controller that drives the PC's step enable and reports processor state back over the debug link. Sits between the debug UART (command RX / data TX byte streams) and the pipeline. It generates `o_step` for continuous or single-step execution, stops on the pipeline's halt indication, and serializes a snapshot of the current PC (and optionally a step counter) to the TX side.

---
 rtl/debug_step_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: debug execution controller between the debug UART and the
// pipeline. Generates the PC step enable for continuous ('c') or single-step
// ('s') execution, stops on the pipeline halt indication, and serializes a
// 4-byte LSB-first PC snapshot ('p') to the UART transmitter.
//
// Optional feature, macro DEBUG_STEP_COUNT_EN: a 32-bit step counter and the
// 'k' command that reports it in the same 4-byte format. With the macro
// undefined, 'k' is an unknown command and is ignored.
//
// TX handshake: a byte transfers on every rising edge where o_tx_valid and
// i_tx_ready are both high; o_tx_data holds steady until that edge, and
// o_tx_valid only drops after a transfer or on reset.
//
// The FSM state is held in state_q, with o_busy/o_step as its decoded views.

module debug_step_ctrl #(
    parameter int SIZE_ADDR_PC = 32,
    parameter int SIZE_CMD     = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [SIZE_CMD-1:0]     i_cmd,
    input  logic                    i_cmd_valid,
    input  logic                    i_halt,
    input  logic [SIZE_ADDR_PC-1:0] i_pc,
    input  logic                    i_tx_ready,
    output logic                    o_step,
    output logic [SIZE_CMD-1:0]     o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_busy,
    output logic                    o_halted
);

    localparam logic [SIZE_CMD-1:0] CMD_RUN   = 8'h63; // 'c'
    localparam logic [SIZE_CMD-1:0] CMD_STEP  = 8'h73; // 's'
    localparam logic [SIZE_CMD-1:0] CMD_PC    = 8'h70; // 'p'
`ifdef DEBUG_STEP_COUNT_EN
    localparam logic [SIZE_CMD-1:0] CMD_COUNT = 8'h6B; // 'k'
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    halted_q;
    logic [SIZE_ADDR_PC-1:0] shift_q;
    logic [1:0]              idx_q;

`ifdef DEBUG_STEP_COUNT_EN
    logic [31:0] count_q;

    // Step counter: counts every cycle in which the step enable is high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= 32'd0;
        end else if (o_step) begin
            count_q <= count_q + 32'd1;
        end
    end
`endif

    // Main controller FSM: command decode, run/step/halt, and byte serializer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
            shift_q  <= '0;
            idx_q    <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Commands are only looked at here; anything arriving
                    // while busy is simply dropped.
                    if (i_cmd_valid) begin
                        if (i_cmd == CMD_RUN && !halted_q) begin
                            state_q <= ST_RUN;
                        end else if (i_cmd == CMD_STEP && !halted_q) begin
                            state_q <= ST_STEP;
                        end else if (i_cmd == CMD_PC) begin
                            state_q <= ST_SEND;
                            shift_q <= i_pc;
                            idx_q   <= 2'd0;
`ifdef DEBUG_STEP_COUNT_EN
                        end else if (i_cmd == CMD_COUNT) begin
                            state_q <= ST_SEND;
                            shift_q <= count_q;
                            idx_q   <= 2'd0;
`endif
                        end
                    end
                end
                ST_RUN: begin
                    // The step in the halt cycle itself still happens.
                    if (i_halt) begin
                        state_q  <= ST_IDLE;
                        halted_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_IDLE;
                    if (i_halt) begin
                        halted_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    // Advance to the next byte only when the current one is taken.
                    if (i_tx_ready) begin
                        shift_q <= shift_q >> SIZE_CMD;
                        idx_q   <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are direct decodes of registered state, so they are glitch-free
    // and change only on the clock edge.
    assign o_step     = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_tx_valid = (state_q == ST_SEND);
    assign o_tx_data  = shift_q[SIZE_CMD-1:0];
    assign o_halted   = halted_q;

endmodule
